// File: rtl/cache_arbiter.sv
// Shares one memory port between the icache and dcache, one line transaction at a time.
// Ties in IDLE go to the side that did not win last; the winner's request is latched at grant.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_addr,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  // state   | meaning
  // IDLE    | no transaction, arbitrate pending requests
  // SERVE_I | icache line read in flight
  // SERVE_D | dcache read or writeback in flight
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;

  state_e                state_q, state_d;
  logic                  last_d_q, last_d_d;   // 1 when dcache won the most recent grant
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;

  logic i_req;
  logic d_req;
  logic grant_d;

  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  assign grant_d = d_req & (~i_req | ~last_d_q);

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d  = SERVE_D;
          last_d_d = 1'b1;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          write_d  = d_write;
        end else if (i_req) begin
          state_d  = SERVE_I;
          last_d_d = 1'b0;
          addr_d   = i_addr;
          write_d  = 1'b0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
    end
  end

  // Commands come purely from registers so memory sees stable values for the whole transaction.
  assign pmem_read  = (state_q != IDLE) & ~write_q;
  assign pmem_write = (state_q != IDLE) &  write_q;
  assign pmem_addr  = addr_q;
  assign pmem_wdata = wdata_q;

  assign i_resp  = (state_q == SERVE_I) & pmem_resp;
  assign d_resp  = (state_q == SERVE_D) & pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single misses, writeback, tie alternation,
// input stability, reset mid-transaction and stray responses.
module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_addr;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int checks = 0;
  int errors = 0;

  localparam logic [LW-1:0] LINE_AB = {32{8'hAB}};
  localparam logic [LW-1:0] LINE_5A = {32{8'h5A}};
  localparam logic [LW-1:0] LINE_C3 = {32{8'hC3}};

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    i_read = 0; i_addr = '0; d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;
    apply_reset();
    #1;
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL reset_pmem_read got %b want 0", pmem_read); end
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL reset_pmem_write got %b want 0", pmem_write); end
    checks++; if ({i_resp, d_resp} !== 2'b00) begin errors++; $display("FAIL reset_resp got %b want 00", {i_resp, d_resp}); end
    checks++; if (pmem_addr !== '0) begin errors++; $display("FAIL reset_pmem_addr got %h want 0", pmem_addr); end
    checks++; if (pmem_wdata !== '0) begin errors++; $display("FAIL reset_pmem_wdata got %h want 0", pmem_wdata); end
  endtask

  task automatic test_icache_miss();
    i_read = 1; i_addr = 32'h0000_0060;
    cyc();
    checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL imiss_grant_read got %b want 1", pmem_read); end
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL imiss_grant_write got %b want 0", pmem_write); end
    checks++; if (pmem_addr !== 32'h60) begin errors++; $display("FAIL imiss_addr got %h want 60", pmem_addr); end
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++; if ({pmem_read, i_resp, d_resp} !== 3'b100) begin errors++; $display("FAIL imiss_wait%0d got %b want 100", k, {pmem_read, i_resp, d_resp}); end
    end
    cyc();
    pmem_resp = 1; pmem_rdata = LINE_AB;
    #1;
    checks++; if (i_resp !== 1'b1) begin errors++; $display("FAIL imiss_resp got %b want 1", i_resp); end
    checks++; if (d_resp !== 1'b0) begin errors++; $display("FAIL imiss_dresp got %b want 0", d_resp); end
    checks++; if (i_rdata !== LINE_AB) begin errors++; $display("FAIL imiss_rdata got %h want %h", i_rdata, LINE_AB); end
    cyc();
    pmem_resp = 0; i_read = 0;
    #1;
    checks++; if ({pmem_read, pmem_write, i_resp} !== 3'b000) begin errors++; $display("FAIL imiss_idle got %b want 000", {pmem_read, pmem_write, i_resp}); end
    cyc();
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL imiss_stay_idle got %b want 0", pmem_read); end
  endtask

  task automatic test_writeback();
    d_write = 1; d_addr = 32'h100; d_wdata = LINE_5A;
    cyc();
    for (int k = 0; k < 3; k++) begin
      checks++; if ({pmem_read, pmem_write} !== 2'b01) begin errors++; $display("FAIL wb_cmd%0d got %b want 01", k, {pmem_read, pmem_write}); end
      checks++; if (pmem_addr !== 32'h100) begin errors++; $display("FAIL wb_addr%0d got %h want 100", k, pmem_addr); end
      checks++; if (pmem_wdata !== LINE_5A) begin errors++; $display("FAIL wb_wdata%0d got %h want %h", k, pmem_wdata, LINE_5A); end
      cyc();
    end
    pmem_resp = 1;
    #1;
    checks++; if ({d_resp, i_resp} !== 2'b10) begin errors++; $display("FAIL wb_resp got %b want 10", {d_resp, i_resp}); end
    cyc();
    pmem_resp = 0; d_write = 0;
    #1;
    checks++; if ({pmem_read, pmem_write, d_resp} !== 3'b000) begin errors++; $display("FAIL wb_idle got %b want 000", {pmem_read, pmem_write, d_resp}); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    i_read = 1; i_addr = 32'h40; d_read = 1; d_addr = 32'h80;
    cyc();
    checks++; if ({pmem_read, pmem_addr} !== {1'b1, 32'h80}) begin errors++; $display("FAIL tie1_grant got %b/%h want 1/80", pmem_read, pmem_addr); end
    pmem_resp = 1; pmem_rdata = LINE_C3;
    #1;
    checks++; if ({d_resp, i_resp} !== 2'b10) begin errors++; $display("FAIL tie1_resp got %b want 10", {d_resp, i_resp}); end
    checks++; if (d_rdata !== LINE_C3) begin errors++; $display("FAIL tie1_rdata got %h want %h", d_rdata, LINE_C3); end
    cyc();
    pmem_resp = 0;
    #1;
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL tie1_idle got %b want 0", pmem_read); end
    cyc();
    checks++; if ({pmem_read, pmem_addr} !== {1'b1, 32'h40}) begin errors++; $display("FAIL tie2_grant_i got %b/%h want 1/40", pmem_read, pmem_addr); end
    pmem_resp = 1;
    #1;
    checks++; if ({d_resp, i_resp} !== 2'b01) begin errors++; $display("FAIL tie2_resp got %b want 01", {d_resp, i_resp}); end
    cyc();
    pmem_resp = 0;
    cyc();
    checks++; if ({pmem_read, pmem_addr} !== {1'b1, 32'h80}) begin errors++; $display("FAIL tie3_grant_d got %b/%h want 1/80", pmem_read, pmem_addr); end
    i_read = 0; d_read = 0;
    pmem_resp = 1;
    cyc();
    pmem_resp = 0;
  endtask

  task automatic test_input_stability();
    d_read = 1; d_addr = 32'h200;
    cyc();
    checks++; if (pmem_addr !== 32'h200) begin errors++; $display("FAIL stab_grant got %h want 200", pmem_addr); end
    d_addr = 32'h300; d_read = 0; d_write = 1;
    cyc();
    checks++; if ({pmem_read, pmem_write, pmem_addr} !== {2'b10, 32'h200}) begin errors++; $display("FAIL stab_hold got %b/%h want 10/200", {pmem_read, pmem_write}, pmem_addr); end
    d_write = 0;
    pmem_resp = 1;
    #1;
    checks++; if (d_resp !== 1'b1) begin errors++; $display("FAIL stab_resp got %b want 1", d_resp); end
    cyc();
    pmem_resp = 0;
  endtask

  task automatic test_reset_mid();
    i_read = 1; i_addr = 32'h60;
    cyc();
    checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL rmid_serve got %b want 1", pmem_read); end
    rst = 1;
    cyc();
    rst = 0; i_read = 0;
    #1;
    checks++; if ({pmem_read, pmem_addr} !== {1'b0, 32'h0}) begin errors++; $display("FAIL rmid_cleared got %b/%h want 0/0", pmem_read, pmem_addr); end
    pmem_resp = 1;
    #1;
    checks++; if ({i_resp, d_resp} !== 2'b00) begin errors++; $display("FAIL rmid_no_resp got %b want 00", {i_resp, d_resp}); end
    cyc();
    pmem_resp = 0;
    i_read = 1; i_addr = 32'h44; d_read = 1; d_addr = 32'h88;
    cyc();
    checks++; if ({pmem_read, pmem_addr} !== {1'b1, 32'h88}) begin errors++; $display("FAIL rmid_tie got %b/%h want 1/88", pmem_read, pmem_addr); end
    i_read = 0; d_read = 0;
    pmem_resp = 1;
    cyc();
    pmem_resp = 0;
  endtask

  task automatic test_stray_resp();
    cyc();
    pmem_resp = 1; pmem_rdata = LINE_5A;
    #1;
    checks++; if ({i_resp, d_resp, pmem_read, pmem_write} !== 4'b0000) begin errors++; $display("FAIL stray_outputs got %b want 0000", {i_resp, d_resp, pmem_read, pmem_write}); end
    checks++; if (i_rdata !== LINE_5A) begin errors++; $display("FAIL stray_passthru got %h want %h", i_rdata, LINE_5A); end
    cyc();
    pmem_resp = 0;
    #1;
    checks++; if ({pmem_read, pmem_write} !== 2'b00) begin errors++; $display("FAIL stray_still_idle got %b want 00", {pmem_read, pmem_write}); end
    i_read = 1; i_addr = 32'h20;
    cyc();
    checks++; if ({pmem_read, pmem_addr} !== {1'b1, 32'h20}) begin errors++; $display("FAIL stray_next_grant got %b/%h want 1/20", pmem_read, pmem_addr); end
    i_read = 0;
    pmem_resp = 1;
    cyc();
    pmem_resp = 0;
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_icache_miss();
    test_writeback();
    test_back_to_back();
    test_input_stability();
    test_reset_mid();
    test_stray_resp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
